// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB constants, functional-unit indices and the broadcast bus type
// consumed by the ROB and reservation stations.
package cdb_arbiter_pkg;

    localparam int NUM_FU   = 5;
    localparam int ROB_IX_W = 3;
    localparam int DATA_W   = 32;
    localparam int FU_IX_W  = 3;

    localparam logic [FU_IX_W-1:0] FU_ALU   = 3'd0;
    localparam logic [FU_IX_W-1:0] FU_BRALU = 3'd1;
    localparam logic [FU_IX_W-1:0] FU_MUL   = 3'd2;
    localparam logic [FU_IX_W-1:0] FU_DIV   = 3'd3;
    localparam logic [FU_IX_W-1:0] FU_MEM   = 3'd4;

    typedef struct packed {
        logic                valid;
        logic [ROB_IX_W-1:0] rob_ix;
        logic [DATA_W-1:0]   value;
    } cdb_t;

    // Round-robin successor of a port index.
    function automatic int wrap_inc(input int ix, input int n);
        return (ix + 1 >= n) ? 0 : ix + 1;
    endfunction

endpackage

// File: rtl/cdb_slot.sv
// One-entry result buffer per functional unit; loads on the edge after a write.
// ready is high when empty or being drained this cycle, so drain and refill share an edge.
module cdb_slot
    import cdb_arbiter_pkg::*;
#(
    parameter int IX_W  = ROB_IX_W,
    parameter int VAL_W = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [IX_W-1:0]  wr_rob_ix,
    input  logic [VAL_W-1:0] wr_data,
    input  logic             drain,
    output logic             ready,
    output logic             valid,
    output logic [IX_W-1:0]  rob_ix,
    output logic [VAL_W-1:0] data
);

    assign ready = !valid || drain;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            rob_ix <= '0;
            data   <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (wr_en && ready) begin
            valid  <= 1'b1;
            rob_ix <= wr_rob_ix;
            data   <= wr_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: buffers one result per FU, broadcasts one per cycle on a
// registered bus (2-cycle min latency); FUs are stalled via fu_read_out when their slot is held.
module cdb_arbiter #(
    parameter int NUM_FU   = cdb_arbiter_pkg::NUM_FU,
    parameter int ROB_IX_W = cdb_arbiter_pkg::ROB_IX_W,
    parameter int DATA_W   = cdb_arbiter_pkg::DATA_W
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             flush_in,
    input  logic [NUM_FU-1:0]                fu_valid_in,
    input  logic [NUM_FU-1:0][ROB_IX_W-1:0]  fu_rob_ix_in,
    input  logic [NUM_FU-1:0][DATA_W-1:0]    fu_data_in,
    output logic [NUM_FU-1:0]                fu_read_out,
    output logic                             cdb_valid_out,
    output logic [ROB_IX_W-1:0]              cdb_rob_ix_out,
    output logic [DATA_W-1:0]                cdb_value_out,
    output logic [2:0]                       cdb_fu_out
);
    import cdb_arbiter_pkg::FU_IX_W;
    import cdb_arbiter_pkg::wrap_inc;

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [PTR_W-1:0]                ptr;
    logic [NUM_FU-1:0]               slot_valid;
    logic [NUM_FU-1:0]               slot_ready;
    logic [NUM_FU-1:0]               grant;
    logic [NUM_FU-1:0][ROB_IX_W-1:0] slot_rob_ix;
    logic [NUM_FU-1:0][DATA_W-1:0]   slot_data;
    logic                            found;
    int                              grant_ix;
    int                              idx;
    logic [ROB_IX_W-1:0]             sel_rob_ix;
    logic [DATA_W-1:0]               sel_data;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_slot
        cdb_slot #(
            .IX_W  (ROB_IX_W),
            .VAL_W (DATA_W)
        ) u_slot (
            .clk       (clk_in),
            .rst_n     (rst_in),
            .flush     (flush_in),
            .wr_en     (fu_valid_in[i]),
            .wr_rob_ix (fu_rob_ix_in[i]),
            .wr_data   (fu_data_in[i]),
            .drain     (grant[i]),
            .ready     (slot_ready[i]),
            .valid     (slot_valid[i]),
            .rob_ix    (slot_rob_ix[i]),
            .data      (slot_data[i])
        );
    end

    assign fu_read_out = slot_ready;

    // First occupied slot at or after ptr, wrapping; a flush cycle grants nothing.
    always_comb begin
        grant      = '0;
        found      = 1'b0;
        grant_ix   = 0;
        idx        = 0;
        sel_rob_ix = '0;
        sel_data   = '0;
        for (int off = 0; off < NUM_FU; off++) begin
            idx = (int'(ptr) + off) % NUM_FU;
            if (!found && !flush_in && slot_valid[idx]) begin
                found      = 1'b1;
                grant_ix   = idx;
                grant[idx] = 1'b1;
                sel_rob_ix = slot_rob_ix[idx];
                sel_data   = slot_data[idx];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            ptr            <= '0;
            cdb_valid_out  <= 1'b0;
            cdb_rob_ix_out <= '0;
            cdb_value_out  <= '0;
            cdb_fu_out     <= '0;
        end else if (found) begin
            ptr            <= PTR_W'(wrap_inc(grant_ix, NUM_FU));
            cdb_valid_out  <= 1'b1;
            cdb_rob_ix_out <= sel_rob_ix;
            cdb_value_out  <= sel_data;
            cdb_fu_out     <= FU_IX_W'(grant_ix);
        end else begin
            cdb_valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: per-cycle comparison against a rule-level model
// plus hand-computed pins for latency, ordering, stalls, flush and reset.
module tb_cdb_arbiter;

    localparam int N = 5;

    logic                clk = 1'b0;
    logic                rst_in;
    logic                flush_in;
    logic [N-1:0]        fu_valid_in;
    logic [N-1:0][2:0]   fu_rob_ix_in;
    logic [N-1:0][31:0]  fu_data_in;
    logic [N-1:0]        fu_read_out;
    logic                cdb_valid_out;
    logic [2:0]          cdb_rob_ix_out;
    logic [31:0]         cdb_value_out;
    logic [2:0]          cdb_fu_out;

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_FU(N), .ROB_IX_W(3), .DATA_W(32)) dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .flush_in       (flush_in),
        .fu_valid_in    (fu_valid_in),
        .fu_rob_ix_in   (fu_rob_ix_in),
        .fu_data_in     (fu_data_in),
        .fu_read_out    (fu_read_out),
        .cdb_valid_out  (cdb_valid_out),
        .cdb_rob_ix_out (cdb_rob_ix_out),
        .cdb_value_out  (cdb_value_out),
        .cdb_fu_out     (cdb_fu_out)
    );

    typedef struct {
        logic [2:0]  ix;
        logic [31:0] d;
    } res_t;

    res_t q [N][$];
    int   tests = 0;
    int   fails = 0;
    logic chk_en = 1'b0;

    // Model state: slot contents, pointer and the expected bus.
    logic [N-1:0] m_sv;
    logic [2:0]   m_ix [N];
    logic [31:0]  m_d  [N];
    int           m_ptr;
    logic         c_vld;
    logic [2:0]   c_ix;
    logic [31:0]  c_val;
    int           c_fu;

    function automatic int find(input logic [N-1:0] occ, input int p);
        for (int k = 0; k < N; k++)
            if (occ[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int g;
        if (!rst_in) begin
            m_sv  = '0;
            m_ptr = 0;
            c_vld = 1'b0;
            c_ix  = '0;
            c_val = '0;
            c_fu  = 0;
        end else if (flush_in) begin
            m_sv  = '0;
            c_vld = 1'b0;
        end else begin
            g = find(m_sv, m_ptr);
            if (g >= 0) begin
                c_vld   = 1'b1;
                c_ix    = m_ix[g];
                c_val   = m_d[g];
                c_fu    = g;
                m_ptr   = (g + 1) % N;
                m_sv[g] = 1'b0;
            end else begin
                c_vld = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (fu_valid_in[i] && !m_sv[i]) begin
                    m_sv[i] = 1'b1;
                    m_ix[i] = fu_rob_ix_in[i];
                    m_d[i]  = fu_data_in[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        int           g;
        logic [N-1:0] er;
        if (chk_en) begin
            g = find(m_sv, m_ptr);
            for (int i = 0; i < N; i++)
                er[i] = !m_sv[i] || (g == i && !flush_in);
            check("cyc_valid", 32'(cdb_valid_out), 32'(c_vld));
            check("cyc_rob_ix", 32'(cdb_rob_ix_out), 32'(c_ix));
            check("cyc_value", cdb_value_out, c_val);
            check("cyc_fu", 32'(cdb_fu_out), 32'(c_fu));
            check("cyc_read", 32'(fu_read_out), 32'(er));
        end
    end

    task automatic push(input int fu, input logic [2:0] ix, input logic [31:0] d);
        res_t r;
        r.ix = ix;
        r.d  = d;
        q[fu].push_back(r);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0) begin
                fu_valid_in[i]  = 1'b1;
                fu_rob_ix_in[i] = q[i][0].ix;
                fu_data_in[i]   = q[i][0].d;
            end else begin
                fu_valid_in[i]  = 1'b0;
                fu_rob_ix_in[i] = '0;
                fu_data_in[i]   = '0;
            end
        end
    endtask

    // One clock: results whose read was high at the edge leave the FU queue.
    task automatic step();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = fu_valid_in & fu_read_out;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (acc[i]) void'(q[i].pop_front());
        drive();
        #1;
    endtask

    task automatic pin(input string name, input logic v, input logic [2:0] ix,
                       input logic [31:0] val, input logic [2:0] fu);
        check({name, "_valid"}, 32'(cdb_valid_out), 32'(v));
        if (v) begin
            check({name, "_rob_ix"}, 32'(cdb_rob_ix_out), 32'(ix));
            check({name, "_value"}, cdb_value_out, val);
            check({name, "_fu"}, 32'(cdb_fu_out), 32'(fu));
        end
    endtask

    initial begin
        rst_in   = 1'b0;
        flush_in = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_in = 1'b1;
        chk_en = 1'b1;
        #1;
        check("rst_valid", 32'(cdb_valid_out), 32'd0);
        check("rst_rob_ix", 32'(cdb_rob_ix_out), 32'd0);
        check("rst_value", cdb_value_out, 32'd0);
        check("rst_fu", 32'(cdb_fu_out), 32'd0);
        check("rst_read", 32'(fu_read_out), 32'h1f);

        // Single alu result: bus valid exactly two cycles after presentation.
        push(0, 3'd3, 32'h0000_002A);
        step();
        step();  pin("single_k1", 1'b0, 3'd0, 32'h0, 3'd0);
        step();  pin("single_k2", 1'b1, 3'd3, 32'h2A, 3'd0);
        step();  pin("single_k3", 1'b0, 3'd0, 32'h0, 3'd0);

        // mul, div, mem together: broadcast in index order, pointer wraps to alu.
        push(2, 3'd1, 32'h100);
        push(3, 3'd2, 32'h200);
        push(4, 3'd4, 32'h400);
        step();
        step();
        step();  pin("simul_mul", 1'b1, 3'd1, 32'h100, 3'd2);
        step();  pin("simul_div", 1'b1, 3'd2, 32'h200, 3'd3);
        step();  pin("simul_mem", 1'b1, 3'd4, 32'h400, 3'd4);
        push(1, 3'd5, 32'h11);
        push(0, 3'd6, 32'h22);
        step();
        step();
        step();  pin("wrap_alu", 1'b1, 3'd6, 32'h22, 3'd0);
        step();  pin("wrap_bralu", 1'b1, 3'd5, 32'h11, 3'd1);
        step();

        // alu and mul streaming together: grants alternate starting with mul.
        for (int k = 0; k < 4; k++) begin
            push(0, 3'(k), 32'hA0 + k);
            push(2, 3'(4 + k), 32'hC0 + k);
        end
        step();
        step();
        for (int j = 0; j < 8; j++) begin
            step();
            if (j % 2 == 0) pin("alt_mul", 1'b1, 3'(4 + j / 2), 32'hC0 + j / 2, 3'd2);
            else            pin("alt_alu", 1'b1, 3'(j / 2), 32'hA0 + j / 2, 3'd0);
        end
        step();  pin("alt_idle", 1'b0, 3'd0, 32'h0, 3'd0);

        // brAlu held full while div wins; its second result waits for read.
        push(2, 3'd1, 32'h300);
        step();
        step();
        step();  pin("blk_pre", 1'b1, 3'd1, 32'h300, 3'd2);
        push(1, 3'd2, 32'hB0);
        push(1, 3'd3, 32'hB1);
        push(3, 3'd4, 32'hD0);
        step();
        step();
        check("blk_read1_low", 32'(fu_read_out[1]), 32'd0);
        check("blk_read3_high", 32'(fu_read_out[3]), 32'd1);
        step();  pin("blk_div", 1'b1, 3'd4, 32'hD0, 3'd3);
        check("blk_read1_high", 32'(fu_read_out[1]), 32'd1);
        step();  pin("blk_br0", 1'b1, 3'd2, 32'hB0, 3'd1);
        step();  pin("blk_br1", 1'b1, 3'd3, 32'hB1, 3'd1);
        step();  pin("blk_idle", 1'b0, 3'd0, 32'h0, 3'd0);

        // Flush with three slots full: nothing is ever broadcast.
        push(0, 3'd1, 32'hF0);
        push(2, 3'd2, 32'hF2);
        push(4, 3'd3, 32'hF4);
        step();
        step();
        flush_in = 1'b1;
        #1;
        check("flush_read_during", 32'(fu_read_out), 32'h0a);
        step();
        flush_in = 1'b0;
        #1;
        check("flush_valid", 32'(cdb_valid_out), 32'd0);
        check("flush_read", 32'(fu_read_out), 32'h1f);
        repeat (3) begin
            step();
            check("flush_quiet", 32'(cdb_valid_out), 32'd0);
        end

        // Reset with two slots full, then alu beats mem because ptr is back at 0.
        push(1, 3'd5, 32'h55);
        push(3, 3'd6, 32'h66);
        step();
        step();
        rst_in = 1'b0;
        step();
        rst_in = 1'b1;
        #1;
        check("mrst_valid", 32'(cdb_valid_out), 32'd0);
        check("mrst_rob_ix", 32'(cdb_rob_ix_out), 32'd0);
        check("mrst_value", cdb_value_out, 32'd0);
        check("mrst_fu", 32'(cdb_fu_out), 32'd0);
        check("mrst_read", 32'(fu_read_out), 32'h1f);
        push(0, 3'd1, 32'h77);
        push(4, 3'd7, 32'h99);
        step();
        step();  pin("post_k1", 1'b0, 3'd0, 32'h0, 3'd0);
        step();  pin("post_alu", 1'b1, 3'd1, 32'h77, 3'd0);
        step();  pin("post_mem", 1'b1, 3'd7, 32'h99, 3'd4);
        step();  pin("post_idle", 1'b0, 3'd0, 32'h0, 3'd0);

        repeat (2) step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
